// File: rtl/seq_shift_multiplier.sv
// Iterative multiplier: one radix-2 Booth (signed) or shift-add (unsigned) step per clock,
// WIDTH steps per product, with a start/busy/done handshake and an abort input.
module seq_shift_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] high_o,
  output logic [WIDTH-1:0] low_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        m_q;
  logic                    mode_q;
  logic signed [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]        acc_lo_q, acc_lo_d;
  logic                    q_m1_q, q_m1_d;
  logic [CNT_W-1:0]        count_q;
  logic                    accept;
  logic                    step;
  logic                    last_step;

  // One multiply step: returns {acc_hi, acc_lo, q_m1} after the add/subtract and right shift.
  function automatic logic [2*WIDTH+1:0] mul_step(
    input logic signed [WIDTH:0] hi,
    input logic [WIDTH-1:0]      lo,
    input logic                  qm1,
    input logic [WIDTH-1:0]      m,
    input logic                  signed_mode
  );
    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] sum;
    m_ext = signed_mode ? $signed({m[WIDTH-1], m}) : $signed({1'b0, m});
    sum   = hi;
    if (signed_mode) begin
      if (lo[0] && !qm1)
        sum = hi - m_ext;
      else if (!lo[0] && qm1)
        sum = hi + m_ext;
    end else if (lo[0]) begin
      sum = hi + m_ext;
    end
    // The unsigned sum is never negative, so zero fill gives the logical shift incl. carry.
    return {(signed_mode ? sum[WIDTH] : 1'b0), sum[WIDTH:1], sum[0], lo[WIDTH-1:1], lo[0]};
  endfunction

  assign accept    = start_i && (state_q == IDLE || state_q == DONE);
  assign step      = (state_q == RUN) && !abort_i;
  assign last_step = (count_q == CNT_W'(1));
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);

  always_comb begin
    {acc_hi_d, acc_lo_d, q_m1_d} = mul_step(acc_hi_q, acc_lo_q, q_m1_q, m_q, mode_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (abort_i)        state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      mode_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      q_m1_q   <= 1'b0;
      count_q  <= '0;
      high_o   <= '0;
      low_o    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        m_q      <= a_i;
        mode_q   <= signed_i;
        acc_hi_q <= '0;
        acc_lo_q <= b_i;
        q_m1_q   <= 1'b0;
        count_q  <= CNT_W'(WIDTH);
      end else if (step) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        q_m1_q   <= q_m1_d;
        count_q  <= count_q - CNT_W'(1);
        // Results are published only when the final step completes.
        if (last_step) begin
          high_o <= acc_hi_d[WIDTH-1:0];
          low_o  <= acc_lo_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Self-checking bench for seq_shift_multiplier: WIDTH=32 and WIDTH=8 instances,
// directed vectors, handshake corner cases and randomized operands against a plain-arithmetic model.
module tb_seq_shift_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, sgn32, abort32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sgn8, abort8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  int compared   = 0;
  int mismatched = 0;

  seq_shift_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start32), .signed_i(sgn32), .a_i(a32), .b_i(b32),
    .abort_i(abort32), .busy_o(busy32), .done_o(done32), .high_o(hi32), .low_o(lo32)
  );

  seq_shift_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .signed_i(sgn8), .a_i(a8), .b_i(b8),
    .abort_i(abort8), .busy_o(busy8), .done_o(done8), .high_o(hi8), .low_o(lo8)
  );

  typedef struct {
    bit          w8;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] prod(input bit w8);
    return w8 ? {48'b0, hi8, lo8} : {hi32, lo32};
  endfunction

  function automatic logic busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  // Reference: exact product from ordinary integer arithmetic.
  function automatic logic [63:0] model(input bit w8, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    longint      sp;
    logic [63:0] up;
    if (w8) begin
      if (s) sp = longint'($signed(a[7:0])) * longint'($signed(b[7:0]));
      else   sp = longint'({24'b0, a[7:0]}) * longint'({24'b0, b[7:0]});
      return {48'b0, 16'(sp)};
    end
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    up = {32'b0, a} * {32'b0, b};
    return up;
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic ab);
    if (w8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sgn8 = s; abort8 = ab;
    end else begin
      start32 = st; a32 = a; b32 = b; sgn32 = s; abort32 = ab;
    end
  endtask

  // Present a start for one edge; returns just after the accepting edge.
  task automatic launch(input bit w8, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ab);
    drive(w8, 1'b1, a, b, s, ab);
    @(posedge clk); #1;
    drive(w8, 1'b0, a, b, s, 1'b0);
  endtask

  task automatic wait_done(input bit w8, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done(w8)) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done_o within 100 cycles expected a pulse");
    end
  endtask

  task automatic run_check(input bit w8, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input string name);
    int cyc;
    launch(w8, a, b, s, 1'b0);
    chk({name, "_busy"}, 64'(busy(w8)), 64'd1);
    wait_done(w8, cyc);
    chk({name, "_lat"}, 64'(cyc), w8 ? 64'd8 : 64'd32);
    chk(name, prod(w8), exp);
    chk({name, "_busy_at_done"}, 64'(busy(w8)), 64'd0);
    @(posedge clk); #1;
    chk({name, "_done_1cyc"}, 64'(done(w8)), 64'd0);
  endtask

  initial begin
    int          cyc;
    bit          seen;
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0] = '{1'b0, 32'h2,        32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[1] = '{1'b0, 32'h2,        32'hFFFF_FFFE, 1'b0, 64'h0000_0001_FFFF_FFFC};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[4] = '{1'b0, 32'h8000_0000, 32'h1,        1'b1, 64'hFFFF_FFFF_8000_0000};
    tbl[5] = '{1'b0, 32'h0,        32'h1234_5678, 1'b1, 64'h0};
    tbl[6] = '{1'b1, 32'h80,       32'hFF,        1'b1, 64'h0080};
    tbl[7] = '{1'b1, 32'hFF,       32'hFF,        1'b0, 64'hFE01};
    tbl[8] = '{1'b1, 32'h7F,       32'h80,        1'b1, 64'hC080};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk("reset_prod", prod(1'b0), 64'h0);
    chk("reset_busy", 64'(busy32), 64'd0);
    chk("reset_done", 64'(done32), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_check(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, $sformatf("vec%0d", i));

    // Back-to-back: second start (with a simultaneous abort) lands in the DONE cycle.
    launch(1'b0, 32'd3, 32'd5, 1'b0, 1'b0);
    wait_done(1'b0, cyc);
    chk("b2b_first", prod(1'b0), 64'd15);
    launch(1'b0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("b2b_busy", 64'(busy32), 64'd1);
    chk("b2b_done_drop", 64'(done32), 64'd0);
    wait_done(1'b0, cyc);
    chk("b2b_lat", 64'(cyc), 64'd32);
    chk("b2b_second", prod(1'b0), 64'hFFFF_FFFF_FFFF_FFF9);
    @(posedge clk); #1;

    // Start pulse with new operands while running must be ignored.
    launch(1'b0, 32'd1000, 32'd77, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd5, 32'd3, 1'b1, 1'b0);
    wait_done(1'b0, cyc);
    chk("midrun_lat", 64'(cyc + 6), 64'd32);
    chk("midrun_prod", prod(1'b0), 64'd77000);
    @(posedge clk); #1;

    // Abort in the tenth RUN cycle.
    launch(1'b0, 32'd12345, 32'd678, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    chk("abort_busy", 64'(busy32), 64'd0);
    chk("abort_done", 64'(done32), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_keep", prod(1'b0), 64'd77000);

    // Randomized operands against the model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_check(1'b0, ra, rb, rs, model(1'b0, ra, rb, rs), $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_check(1'b1, ra, rb, rs, model(1'b1, ra, rb, rs), $sformatf("rnd8_%0d", i));
    end

    // Asynchronous reset mid-operation clears everything without a clock edge.
    launch(1'b0, 32'd9, 32'd9, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_prod", prod(1'b0), 64'h0);
    chk("rst_mid_busy", 64'(busy32), 64'd0);
    chk("rst_mid_done", 64'(done32), 64'd0);
    chk("rst_mid_prod8", prod(1'b1), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    run_check(1'b0, 32'hFFFF_FFF0, 32'd16, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_shift_multiplier.md
Name: seq_shift_multiplier

Overview:
Parametrised iterative multiplier for the ALU. It holds a high/low accumulator pair and performs one shift-multiply step per clock, so a full product takes WIDTH cycles. It supports signed (radix-2 Booth) and unsigned (shift-add) modes, selected per operation. A start/busy/done handshake connects it to the execute-stage controller, and the 2*WIDTH-bit product is returned as high/low words.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits; legal values are 4 and above.
CNT_W, $clog2(WIDTH+1), width of the step counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  request a multiply; sampled only in IDLE or DONE
signed_i  input  1  1 = both operands two's complement (Booth); 0 = unsigned (shift-add); sampled with start_i
a_i  input  WIDTH  multiplicand; sampled with start_i
b_i  input  WIDTH  multiplier; sampled with start_i
abort_i  input  1  synchronous cancel of an operation in progress
busy_o  output  1  high while an operation is running
done_o  output  1  one-cycle pulse when the product is valid
high_o  output  WIDTH  upper product word
low_o  output  WIDTH  lower product word

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0: state=IDLE, busy_o=0, done_o=0, high_o=0, low_o=0, counter=0, internal registers=0. Reset asserted mid-operation aborts immediately. The first start is accepted on the first clk edge after rst_n deasserts.
- States: IDLE, RUN, DONE.
- Accepting start: start_i=1 in IDLE or DONE at edge E:
  - latch M=a_i and mode=signed_i;
  - load acc_hi=0, acc_lo=b_i, q_m1=0, count=WIDTH;
  - go to RUN; busy_o=1 and done_o=0 after E.
- start_i in RUN is ignored, with no effect on the operation or the operand latches.
- acc_hi is WIDTH+1 bits internally, so the most negative multiplicand and the unsigned carry both fit.
- RUN step, signed mode (Booth): inspect {acc_lo[0], q_m1}.
  - 01: acc_hi += sext(M).
  - 10: acc_hi -= sext(M).
  - 00 or 11: no change.
  - Then arithmetic-shift {acc_hi, acc_lo, q_m1} right by 1.
- RUN step, unsigned mode: if acc_lo[0]=1, acc_hi += zext(M). Then logical-shift {acc_hi, acc_lo} right by 1.
- Each RUN step decrements count. At the step where count goes 1->0, the state goes to DONE.
- Latency: start at edge E gives done_o=1 after edge E+WIDTH, for exactly one cycle. busy_o falls in the same cycle that done_o rises.
- Output update: high_o/low_o load acc_hi[WIDTH-1:0]/acc_lo only on the RUN->DONE transition. They hold that value until the next completed operation or reset, and never show partial products.
- DONE lasts one cycle, then IDLE. A start in the DONE cycle is accepted (back-to-back): busy_o=1 on the next cycle and done_o drops.
- abort_i=1 in RUN returns to IDLE at the next edge: busy_o=0, done_o stays 0, high_o/low_o keep their previous values.
- abort_i in IDLE or DONE has no effect.
- abort_i and start_i together in DONE: abort has no effect and start is accepted.
- Results are exact 2*WIDTH-bit products; there is no overflow flag.
  - Signed: product of the two's-complement values.
  - Unsigned: product of the unsigned values.

Test Plan:
- WIDTH=32, signed_i=1, a=2, b=0xFFFFFFFE → done_o exactly 32 cycles after start; {high_o,low_o}=0xFFFFFFFF_FFFFFFFC.
- Same operands with signed_i=0 → 0x00000001_FFFFFFFC. Also 0xFFFFFFFF×0xFFFFFFFF unsigned → 0xFFFFFFFE_00000001.
- Signed 0x80000000×0x80000000 → 0x40000000_00000000; signed 0x80000000×1 → 0xFFFFFFFF_80000000. Checks the WIDTH+1 accumulator.
- Back-to-back: start 3×5 unsigned, assert start again with 7×(−1) signed in the DONE cycle → outputs 15, then 0xFFFFFFFF_FFFFFFF9. Pulse start_i and change a_i mid-RUN → result unaffected.
- Abort at cycle 10 of RUN → busy_o low next cycle, done_o never pulses, outputs keep the prior product. Then drop rst_n mid-RUN → all outputs 0 immediately, with no clock needed.
- WIDTH=8 instance: signed −128×−1 → high=0x00, low=0x80; unsigned 255×255 → 0xFE01; done_o 8 cycles after start.
